// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding imem request, IF/ID register with stall hold and redirect flush.
// Optional FETCH_PERF_COUNT_EN adds fetch and bubble performance counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_read,
  output logic [31:0] imem_address,
  input  logic        imem_resp,
  input  logic [31:0] imem_rdata,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [4:0]  rd
`ifdef FETCH_PERF_COUNT_EN
  ,
  output logic [31:0] perf_fetch_count,
  output logic [31:0] perf_bubble_count
`endif
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;
  localparam logic [XLEN-1:0] INC = 32'd4;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_addr_q, req_addr_d;
  logic            read_q, read_d;
  logic [XLEN-1:0] hold_pc_q, hold_pc_d;
  logic [XLEN-1:0] hold_instr_q, hold_instr_d;
  logic            if_valid_q, if_valid_d;
  logic [XLEN-1:0] if_pc_q, if_pc_d;
  logic [XLEN-1:0] if_instr_q, if_instr_d;
  logic            load;
  logic [XLEN-1:0] load_pc, load_instr;
  logic [XLEN-1:0] redir_pc;

  assign redir_pc = redirect_pc & 32'hFFFF_FFFC;

  // Next-state, PC and IF/ID update
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_addr_d   = req_addr_q;
    hold_pc_d    = hold_pc_q;
    hold_instr_d = hold_instr_q;
    load         = 1'b0;
    load_pc      = '0;
    load_instr   = NOP;
    if_valid_d   = if_valid_q;
    if_pc_d      = if_pc_q;
    if_instr_d   = if_instr_q;

    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (imem_resp) begin
          if (redirect_i) begin
            pc_d = redir_pc;
          end else if (stall_i) begin
            hold_pc_d    = req_addr_q;
            hold_instr_d = imem_rdata;
            pc_d         = req_addr_q + INC;
            state_d      = S_HOLD;
          end else begin
            load       = 1'b1;
            load_pc    = req_addr_q;
            load_instr = imem_rdata;
            pc_d       = req_addr_q + INC;
          end
        end else if (redirect_i) begin
          pc_d    = redir_pc;
          state_d = S_DRAIN;
        end
      end
      S_HOLD: begin
        if (redirect_i) begin
          pc_d         = redir_pc;
          hold_pc_d    = '0;
          hold_instr_d = '0;
          state_d      = S_FETCH;
        end else if (!stall_i) begin
          load       = 1'b1;
          load_pc    = hold_pc_q;
          load_instr = hold_instr_q;
          state_d    = S_FETCH;
        end
      end
      S_DRAIN: begin
        if (redirect_i) pc_d = redir_pc;
        if (imem_resp) state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase

    // A new request address is taken on entry to FETCH and after every completion
    if (state_d == S_FETCH && (state_q != S_FETCH || imem_resp)) req_addr_d = pc_d;

    if (redirect_i) begin
      if_valid_d = 1'b0;
      if_pc_d    = '0;
      if_instr_d = NOP;
    end else if (stall_i) begin
      if_valid_d = if_valid_q;
    end else if (load) begin
      if_valid_d = 1'b1;
      if_pc_d    = load_pc;
      if_instr_d = load_instr;
    end else begin
      if_valid_d = 1'b0;
      if_pc_d    = '0;
      if_instr_d = NOP;
    end
  end

  assign read_d = (state_d == S_FETCH) || (state_d == S_DRAIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      req_addr_q   <= RESET_PC;
      read_q       <= 1'b0;
      hold_pc_q    <= '0;
      hold_instr_q <= '0;
      if_valid_q   <= 1'b0;
      if_pc_q      <= '0;
      if_instr_q   <= NOP;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_addr_q   <= req_addr_d;
      read_q       <= read_d;
      hold_pc_q    <= hold_pc_d;
      hold_instr_q <= hold_instr_d;
      if_valid_q   <= if_valid_d;
      if_pc_q      <= if_pc_d;
      if_instr_q   <= if_instr_d;
    end
  end

  assign imem_read    = read_q;
  assign imem_address = req_addr_q;
  assign if_valid     = if_valid_q;
  assign if_pc        = if_pc_q;
  assign if_instr     = if_instr_q;
  assign opcode       = if_instr_q[6:0];
  assign funct3       = if_instr_q[14:12];
  assign funct7       = if_instr_q[31:25];
  assign rd           = if_instr_q[11:7];

`ifdef FETCH_PERF_COUNT_EN
  logic [XLEN-1:0] fetch_cnt_q, bubble_cnt_q;

  // Bubble: a non-stalled cycle whose IF/ID update carries no instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (load) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (!stall_i && !if_valid_d) bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign perf_fetch_count  = fetch_cnt_q;
  assign perf_bubble_count = bubble_cnt_q;
`endif

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0060, is the first fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 imem_read  output  1  instruction-memory read request; held high until imem_resp.
REQ-005 imem_address  output  32  request address; stable while imem_read is high.
REQ-006 imem_resp  input  1  single-cycle read completion.
REQ-007 imem_rdata  input  32  instruction word; valid when imem_resp is high.
REQ-008 stall_i  input  1  decode/hazard stall; IF/ID register holds its contents.
REQ-009 redirect_i  input  1  branch/jump taken; flush and refetch from redirect_pc.
REQ-010 redirect_pc  input  32  redirect target; bits [1:0] are ignored and treated as 0.
REQ-011 if_valid  output  1  IF/ID register holds a real instruction.
REQ-012 if_pc  output  32  PC of the IF/ID instruction.
REQ-013 if_instr  output  32  IF/ID instruction word; 32'h0000_0013 (NOP) when if_valid is 0.
REQ-014 opcode / funct3 / funct7 / rd  output  7/3/7/5  if_instr[6:0] / [14:12] / [31:25] / [11:7], driven combinationally to the decoder.

Function
REQ-015 The FSM SHALL have states IDLE, FETCH, HOLD and DRAIN; imem_read is 1 in FETCH and DRAIN and 0 otherwise.
REQ-016 IDLE SHALL go to FETCH unconditionally on the next cycle.
REQ-017 FETCH SHALL drive imem_address = req_addr, where req_addr latches pc on entry and after each completion.
REQ-018 FETCH with imem_resp, no redirect and no stall SHALL load IF/ID {valid=1, pc=req_addr, instr=imem_rdata}, set pc += 4 and stay in FETCH (back-to-back issue, 1 instruction/cycle at single-cycle memory).
REQ-019 FETCH with imem_resp and stall_i, no redirect, SHALL capture the PC/instruction into the hold register, set pc += 4 and go to HOLD.
REQ-020 HOLD with stall_i low SHALL load IF/ID from the hold register and go to FETCH; while stall_i is high it SHALL remain in HOLD.
REQ-021 FETCH with redirect_i and no imem_resp SHALL set pc = redirect_pc and go to DRAIN; the outstanding request address is kept unchanged.
REQ-022 DRAIN SHALL keep imem_read high at the old address, discard the response data on imem_resp, and then go to FETCH using the updated pc.
REQ-023 Redirect in the same cycle as imem_resp in FETCH SHALL discard the data, set pc = redirect_pc and stay in FETCH.
REQ-024 Redirect in HOLD SHALL discard the hold register and go to FETCH at redirect_pc.
REQ-025 Redirect in DRAIN SHALL overwrite pc with the newest redirect_pc and remain in DRAIN.
REQ-026 IF/ID priority SHALL be: redirect (if_valid <= 0, if_instr <= NOP), then stall (hold), then load, then bubble (if_valid <= 0).
REQ-027 PC arithmetic SHALL be modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.

Reset
REQ-028 With rst_n low: state = IDLE, pc = RESET_PC, req_addr = RESET_PC, imem_read = 0, if_valid = 0, if_pc = 0, if_instr = 32'h0000_0013, hold register cleared.
REQ-029 Reset asserted mid-request SHALL abandon the request; no response is consumed after rst_n rises until a new request is issued.

Configuration
REQ-030 Macro FETCH_PERF_COUNT_EN SHALL add the 32-bit outputs perf_fetch_count (responses loaded into IF/ID) and perf_bubble_count (cycles with no stall and if_valid loaded as 0); both are reset to 0 and wrap at 2^32.
REQ-031 Without FETCH_PERF_COUNT_EN, these ports and counters SHALL NOT exist and all other behaviour SHALL be identical.

Verification
REQ-032 Reset, then single-cycle memory returning 32'h0000_0093 -> first request at 0x60; if_valid=1, if_pc=0x60, opcode=7'h13, rd=1 one cycle after resp.
REQ-033 stall_i high 3 cycles while resp arrives for 0x64 -> state HOLD, imem_read=0, IF/ID unchanged; 0x64 enters IF/ID the cycle after stall_i drops.
REQ-034 redirect_i to 0x200 while a 4-cycle-latency request is outstanding at 0x68 -> imem_address stays 0x68 until resp; data is dropped; next request is at 0x200; if_valid=0 throughout.
REQ-035 redirect_i and stall_i asserted together with a valid IF/ID entry -> if_valid=0 and if_instr=32'h0000_0013 on the next cycle.
REQ-036 redirect_pc=32'hFFFF_FFFE -> request at 0xFFFF_FFFC, next request at 0x0000_0000.
REQ-037 rst_n pulsed low mid-DRAIN -> all outputs take reset values immediately; fetch restarts at 0x60 (with the macro defined, both counters read 0).
